// File: rtl/mem_miss_ctrl.sv
// rtl/mem_miss_ctrl.sv - MEM-stage data-cache miss sequencer: stall, dirty write-back, word refill.
// Optional miss counter enabled by defining MEM_MISS_CNT_EN.
module mem_miss_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int IDX_W       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_access,
    input  logic              hit,
    input  logic              dirty,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] victim_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              refill_we,
    output logic [IDX_W-1:0]  refill_idx,
    output logic              stall,
    output logic              wb_en,
    output logic [15:0]       miss_count
);

    typedef enum logic [1:0] {IDLE, WBACK, REFILL, RESUME} state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BLOCK_WORDS * 4 - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  line_base_q, line_base_d;
    logic [ADDR_W-1:0]  vic_base_q, vic_base_d;
    logic               miss;
    logic               last;
    logic [ADDR_W-1:0]  offset;

    assign miss       = mem_access & ~hit;
    assign last       = (cnt_q == IDX_W'(BLOCK_WORDS - 1));
    assign offset     = ADDR_W'({cnt_q, 2'b00});
    assign refill_idx = cnt_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_base_d = line_base_q;
        vic_base_d  = vic_base_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = line_base_q + offset;
        refill_we   = 1'b0;
        stall       = 1'b1;
        wb_en       = 1'b0;
        case (state_q)
            IDLE: begin
                stall = miss;
                wb_en = ~miss;
                if (miss) begin
                    line_base_d = addr & ~LINE_MASK;
                    vic_base_d  = victim_addr;
                    cnt_d       = '0;
                    state_d     = dirty ? WBACK : REFILL;
                end
            end
            WBACK: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = vic_base_q + offset;
                // cnt wraps to 0 on the last beat because BLOCK_WORDS is a power of 2
                if (mem_ack) begin
                    cnt_d = cnt_q + IDX_W'(1);
                    if (last) state_d = REFILL;
                end
            end
            REFILL: begin
                mem_req   = 1'b1;
                refill_we = mem_ack;
                if (mem_ack) begin
                    cnt_d = cnt_q + IDX_W'(1);
                    if (last) state_d = RESUME;
                end
            end
            RESUME: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_base_q <= '0;
            vic_base_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_base_q <= line_base_d;
            vic_base_q  <= vic_base_d;
        end
    end

`ifdef MEM_MISS_CNT_EN
    logic        miss_accept;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    assign miss_accept = (state_q == IDLE) & miss;

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (miss_accept && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) miss_cnt_q <= '0;
        else     miss_cnt_q <= miss_cnt_d;
    end

    assign miss_count = miss_cnt_q;
`else
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_miss_ctrl.sv
// tb/tb_mem_miss_ctrl.sv - scoreboard bench for mem_miss_ctrl.
module tb_mem_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_access, hit, dirty, mem_ack;
    logic [31:0] addr, victim_addr, mem_addr;
    logic        mem_req, mem_we, refill_we, stall, wb_en;
    logic [1:0]  refill_idx;
    logic [15:0] miss_count;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  idx;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_misses = 0;
    int    ack_gap = 0;
    int    gap_cnt = 0;
    int    lat;
    logic  prev_req;

    mem_miss_ctrl #(.ADDR_W(32), .BLOCK_WORDS(4), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .mem_access(mem_access), .hit(hit), .dirty(dirty),
        .addr(addr), .victim_addr(victim_addr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .refill_we(refill_we),
        .refill_idx(refill_idx), .stall(stall), .wb_en(wb_en), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_count();
`ifdef MEM_MISS_CNT_EN
        return 16'(exp_misses);
`else
        return 16'h0000;
`endif
    endfunction

    always @(posedge clk) begin
        #1;
        gap_cnt++;
        mem_ack = (ack_gap == 0) ? 1'b1 : ((gap_cnt % 3) == 0);
    end

    always @(negedge clk) begin
        if (!rst && mem_req) begin
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_beat", mem_addr, 32'h0);
            end else begin
                chk(mem_we == sb[0].we, "beat_we", 32'(mem_we), 32'(sb[0].we));
                chk(mem_addr == sb[0].addr, "beat_addr", mem_addr, sb[0].addr);
                chk(refill_we == (mem_ack & ~sb[0].we), "beat_refill_we", 32'(refill_we),
                    32'(mem_ack & ~sb[0].we));
                if (!sb[0].we) chk(refill_idx == sb[0].idx, "beat_idx", 32'(refill_idx), 32'(sb[0].idx));
                if (mem_ack) void'(sb.pop_front());
            end
        end
    end

    task automatic push_line(input logic we, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b.we = we; b.addr = base + 32'(4 * i); b.idx = 2'(i);
            sb.push_back(b);
        end
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] v, input logic d,
                           input int gap, input int exp_lat);
        @(posedge clk); #1;
        ack_gap = gap;
        mem_access = 1'b1; hit = 1'b0; dirty = d; addr = a; victim_addr = v;
        if (d) push_line(1'b1, v);
        push_line(1'b0, {a[31:4], 4'h0});
        exp_misses++;
        @(negedge clk);
        chk(stall == 1'b1, "miss_stall_same_cycle", 32'(stall), 32'h1);
        chk(wb_en == 1'b0, "miss_wb_en_same_cycle", 32'(wb_en), 32'h0);
        lat = 0;
        prev_req = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                hit = 1'b1; dirty = ~d; addr = 32'hDEAD_BEEF; victim_addr = 32'h5555_0000;
            end
            @(negedge clk);
            if (!stall) begin lat = k; break; end
            prev_req = mem_req;
        end
        chk(lat != 0, "stall_release_timeout", 32'(lat), 32'(exp_lat));
        if (exp_lat != 0) chk(lat == exp_lat, "miss_latency", 32'(lat), 32'(exp_lat));
        chk(prev_req == 1'b0, "resume_no_req", 32'(prev_req), 32'h0);
        chk(wb_en == 1'b1, "post_miss_wb_en", 32'(wb_en), 32'h1);
        chk(sb.size() == 0, "scoreboard_drained", 32'(sb.size()), 32'h0);
        sb.delete();
        ack_gap = 0;
        mem_access = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_access = 1'b0; hit = 1'b0; dirty = 1'b0; mem_ack = 1'b0;
        addr = '0; victim_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(mem_req == 1'b0, "reset_mem_req", 32'(mem_req), 32'h0);
        chk(stall == 1'b0, "reset_stall", 32'(stall), 32'h0);
        chk(wb_en == 1'b1, "reset_wb_en", 32'(wb_en), 32'h1);
        chk(refill_we == 1'b0, "reset_refill_we", 32'(refill_we), 32'h0);
        chk(miss_count == 16'h0, "reset_miss_count", 32'(miss_count), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        mem_access = 1'b1; hit = 1'b1; addr = 32'h0000_0040;
        repeat (10) begin
            @(negedge clk);
            chk(stall == 1'b0 && wb_en == 1'b1 && mem_req == 1'b0, "hit_no_stall",
                {29'h0, stall, wb_en, mem_req}, 32'h2);
        end
        mem_access = 1'b0;

        do_miss(32'h0000_1234, 32'h0000_7000, 1'b0, 0, 6);
        chk(miss_count == exp_count(), "count_after_clean", 32'(miss_count), 32'(exp_count()));
        do_miss(32'h0000_2468, 32'h0000_8000, 1'b1, 0, 10);
        chk(miss_count == exp_count(), "count_after_dirty", 32'(miss_count), 32'(exp_count()));
        do_miss(32'h0001_0F0C, 32'h0000_9000, 1'b0, 3, 0);
        chk(miss_count == exp_count(), "count_after_three", 32'(miss_count), 32'(exp_count()));

        // reset while REFILL sits on beat 2: only beats 0 and 1 complete
        @(posedge clk); #1;
        mem_access = 1'b1; hit = 1'b0; dirty = 1'b0; addr = 32'h0000_3000;
        for (int i = 0; i < 2; i++) begin
            beat_t b;
            b.we = 1'b0; b.addr = 32'h0000_3000 + 32'(4 * i); b.idx = 2'(i);
            sb.push_back(b);
        end
        @(posedge clk); #1 hit = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk(refill_idx == 2'd2 && mem_req == 1'b1, "pre_reset_beat2", {30'h0, refill_idx}, 32'h2);
        rst = 1'b1; mem_access = 1'b0;
        #1;
        chk(mem_req == 1'b0, "async_reset_mem_req", 32'(mem_req), 32'h0);
        chk(stall == 1'b0, "async_reset_stall", 32'(stall), 32'h0);
        chk(refill_idx == 2'd0, "async_reset_cnt", 32'(refill_idx), 32'h0);
        chk(sb.size() == 0, "reset_beats_drained", 32'(sb.size()), 32'h0);
        exp_misses = 0;
        @(negedge clk);
        chk(miss_count == 16'h0, "reset_clears_count", 32'(miss_count), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        do_miss(32'hFFFF_FFF8, 32'h0000_A000, 1'b0, 0, 6);
        chk(miss_count == exp_count(), "count_after_reset_miss", 32'(miss_count), 32'(exp_count()));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
